// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI requester arbiter.
// Defaults match the SPI controller integration.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } arb_state_t;

  localparam int DEF_GAP_CYCLES     = 200;
  localparam int DEF_TIMEOUT_CYCLES = 65535;

  // Width of an unsigned counter that must reach max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Round-robin picker: first set request bit
// searching upward from i_ptr+1, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  logic [IDX_W-1:0] w_cand;

  // Scan all positions once, starting just past the last owner.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_valid && i_req[w_cand]) begin
        o_valid = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI controller
// between requesters, with timeout and idle gap.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_dir,
  input  logic [NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] err,
  output logic               spi_tx_en,
  output logic               spi_rx_en,
  output logic               mode_select,
  input  logic               spi_over,
  output logic               busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TO_W  = cnt_w(TIMEOUT_CYCLES);
  localparam int GP_W  = cnt_w(GAP_CYCLES);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GP_W-1:0] GP_MAX =
    GP_W'(GAP_CYCLES);

  localparam logic [IDX_W-1:0] PTR_RST =
    IDX_W'(NUM_REQ - 1);

  arb_state_t r_state;
  arb_state_t w_state_nxt;

  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [NUM_REQ-1:0] r_done;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic [NUM_REQ-1:0] r_err;
  logic [NUM_REQ-1:0] w_err_nxt;

  logic r_tx;
  logic w_tx_nxt;
  logic r_rx;
  logic w_rx_nxt;
  logic r_ms;
  logic w_ms_nxt;

  logic [TO_W-1:0] r_tcnt;
  logic [TO_W-1:0] w_tcnt_nxt;
  logic [GP_W-1:0] r_gcnt;
  logic [GP_W-1:0] w_gcnt_nxt;

  logic r_sync1;
  logic r_sync2;
  logic r_sync2_d;

  logic w_over_rise;
  logic w_timeout;

  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // spi_over comes from the divided clock; resync and edge-detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync2_d <= 1'b0;
    end else begin
      r_sync1   <= spi_over;
      r_sync2   <= r_sync1;
      r_sync2_d <= r_sync2;
    end
  end

  assign w_over_rise = r_sync2 & ~r_sync2_d;
  assign w_timeout   = (r_tcnt == TO_LAST);

  // Next-state, latched controller outputs and owner pulses.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_ms_nxt    = r_ms;
    w_tcnt_nxt  = r_tcnt;
    w_gcnt_nxt  = r_gcnt;

    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt             = ACTIVE;
          w_ptr_nxt               = w_pick_idx;
          w_grant_nxt             = '0;
          w_grant_nxt[w_pick_idx] = 1'b1;
          w_tx_nxt    = req_dir[w_pick_idx];
          w_rx_nxt    = ~req_dir[w_pick_idx];
          w_ms_nxt    = req_mode[w_pick_idx];
          w_tcnt_nxt  = '0;
        end
      end

      ACTIVE: begin
        if (w_over_rise || w_timeout) begin
          w_state_nxt = GAP;
          w_grant_nxt = '0;
          w_tx_nxt    = 1'b0;
          w_rx_nxt    = 1'b0;
          w_ms_nxt    = 1'b0;
          w_gcnt_nxt  = '0;
          if (w_over_rise) begin
            w_done_nxt[r_ptr] = 1'b1;
          end else begin
            w_err_nxt[r_ptr] = 1'b1;
          end
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      GAP: begin
        if (r_gcnt != GP_MAX) begin
          w_gcnt_nxt = r_gcnt + 1'b1;
        end else if (!r_sync2) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= PTR_RST;
      r_grant <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_tx    <= 1'b0;
      r_rx    <= 1'b0;
      r_ms    <= 1'b0;
      r_tcnt  <= '0;
      r_gcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_ms    <= w_ms_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
    end
  end

  assign grant       = r_grant;
  assign done        = r_done;
  assign err         = r_err;
  assign spi_tx_en   = r_tx;
  assign spi_rx_en   = r_rx;
  assign mode_select = r_ms;
  assign busy        = (r_state != IDLE);

endmodule
